t_to_s_stream: RTL

- Streaming converter from two's-complement LLR/check messages to sign-magnitude form, with a valid/ready handshake on both sides.
- Used on the decoder side where min-sum units emit two's-complement results and the message memories and variable-node inputs store sign-magnitude.
- Handles LANES messages per beat, has a 1-cycle pipeline and a 2-entry skid buffer, and saturates the one unrepresentable value.

---
 rtl/ldpc_msg_pkg.sv | 12 +
 rtl/t_to_s_lane.sv | 25 ++
 rtl/t_to_s_stream.sv | 121 ++++++++++++
 3 files changed

// File: rtl/ldpc_msg_pkg.sv
// Shared message-format definitions for the LDPC decoder datapath:
// width, storage type and the two's-complement corner values.
package ldpc_msg_pkg;

    localparam int W = 5;

    typedef logic [W-1:0] msg_t;

    localparam msg_t MSG_MAX_MAG  = msg_t'((1 << (W - 1)) - 1);
    localparam msg_t MSG_MOST_NEG = msg_t'(1 << (W - 1));

endpackage

// File: rtl/t_to_s_lane.sv
// Single-lane two's-complement to sign-magnitude converter; the most
// negative code has no sign-magnitude equivalent and is clamped to -MAX.
module t_to_s_lane
    import ldpc_msg_pkg::*;
(
    input  msg_t tc,
    output msg_t sm,
    output logic sat
);

    msg_t neg;

    always_comb begin
        neg = -tc;
        sm  = tc;
        sat = 1'b0;
        if (tc == MSG_MOST_NEG) begin
            sm  = {1'b1, MSG_MAX_MAG[W-2:0]};
            sat = 1'b1;
        end else if (tc[W-1]) begin
            sm = {1'b1, neg[W-2:0]};
        end
    end

endmodule

// File: rtl/t_to_s_stream.sv
// LANES-wide streaming two's-complement to sign-magnitude converter with a
// 2-entry skid buffer. Define T_TO_S_SAT_COUNT_EN to add the sat_count port.
module t_to_s_stream
    import ldpc_msg_pkg::*;
#(
    parameter int LANES = 4,
    parameter int SATW  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [LANES*W-1:0] in_data,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [LANES*W-1:0] out_data,
    output logic               out_last
`ifdef T_TO_S_SAT_COUNT_EN
    ,
    output logic [SATW-1:0]    sat_count
`endif
);

    logic [LANES*W-1:0] conv_data;
    logic [LANES-1:0]   lane_sat;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        t_to_s_lane u_lane (
            .tc  (in_data[i*W +: W]),
            .sm  (conv_data[i*W +: W]),
            .sat (lane_sat[i])
        );
    end

    logic [LANES*W-1:0] head_data, tail_data;
    logic               head_last, tail_last;
    logic [1:0]         count, count_next;
    logic               ready_q;
    logic               push, pop;

    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign in_ready  = ready_q && !rst;
    assign out_valid = (count != 2'd0);
    assign out_data  = head_data;
    assign out_last  = head_last;

    always_comb begin
        count_next = count + {1'b0, push} - {1'b0, pop};
    end

    // Head always drives the outputs; the tail only fills while the head is stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            count     <= 2'd0;
            ready_q   <= 1'b1;
            head_data <= '0;
            head_last <= 1'b0;
            tail_data <= '0;
            tail_last <= 1'b0;
        end else begin
            count   <= count_next;
            ready_q <= (count_next != 2'd2);
            case (count)
                2'd0: begin
                    if (push) begin
                        head_data <= conv_data;
                        head_last <= in_last;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        head_data <= conv_data;
                        head_last <= in_last;
                    end else if (push) begin
                        tail_data <= conv_data;
                        tail_last <= in_last;
                    end
                end
                default: begin
                    if (pop) begin
                        head_data <= tail_data;
                        head_last <= tail_last;
                    end
                end
            endcase
        end
    end

`ifdef T_TO_S_SAT_COUNT_EN
    localparam int INCW = $clog2(LANES + 1);

    logic [SATW-1:0] sat_count_q;
    logic [INCW-1:0] sat_inc;
    logic [SATW:0]   sat_sum;

    always_comb begin
        sat_inc = '0;
        for (int i = 0; i < LANES; i++) begin
            sat_inc = sat_inc + INCW'(lane_sat[i]);
        end
        sat_sum = {1'b0, sat_count_q} + (SATW+1)'(sat_inc);
    end

    // Sticky at all ones so a long run can never wrap back to a small count.
    always_ff @(posedge clk) begin
        if (rst) begin
            sat_count_q <= '0;
        end else if (push) begin
            sat_count_q <= sat_sum[SATW] ? '1 : sat_sum[SATW-1:0];
        end
    end

    assign sat_count = sat_count_q;
`else
    logic unused_sat;
    assign unused_sat = &{1'b0, lane_sat};
`endif

endmodule
